// File: rtl/universal_shift_register_if.sv
// Command/data bundle for universal_shift_register.
// master drives commands; slave is the shift register.
interface universal_shift_register_if #(
   parameter int N  = 8,
   parameter int AW = $clog2(N) + 1
);
   logic          load;
   logic          start;
   logic          dir;
   logic [1:0]    mode;
   logic [AW-1:0] amt;
   logic [N-1:0]  data_in;
   logic          ser_in;
   logic [N-1:0]  q;
   logic          ser_out;
   logic          busy;
   logic          done;

   modport master (
      output load, start, dir, mode, amt, data_in, ser_in,
      input  q, ser_out, busy, done
   );

   modport slave (
      input  load, start, dir, mode, amt, data_in, ser_in,
      output q, ser_out, busy, done
   );
endinterface

// File: rtl/universal_shift_register.sv
// Load/shift/rotate register with shift-by-K command and busy/done handshake.
// Define SHIFT_BARREL_EN for single-edge barrel execution.
module universal_shift_register #(
   parameter int N = 8
) (
   input logic clk,
   input logic rst,
   universal_shift_register_if.slave bus
);
   localparam int AW = $clog2(N) + 1;
   localparam logic [AW-1:0] NMAX = AW'(N);

   logic [N-1:0]  q_r;
   logic          so_r;
   logic          done_r;
   logic [AW-1:0] k;
   logic [N:0]    nxt;

   assign k = (bus.amt > NMAX) ? NMAX : bus.amt;

   // Returns {bit shifted out, new register value} for a single step.
   function automatic logic [N:0] step(
      input logic [N-1:0] v,
      input logic         d,
      input logic [1:0]   m,
      input logic         si
   );
      logic fill;
      logic so;
      so = d ? v[0] : v[N-1];
      unique case (1'b1)
         (m == 2'b01): fill = d ? v[N-1] : 1'b0;
         (m == 2'b10): fill = so;
         default:      fill = si;
      endcase
      if (d)
         step = {so, fill, v[N-1:1]};
      else
         step = {so, v[N-2:0], fill};
   endfunction

`ifdef SHIFT_BARREL_EN
   function automatic logic [N:0] barrel(
      input logic [N-1:0]  v,
      input logic          d,
      input logic [1:0]    m,
      input logic          si,
      input logic [AW-1:0] cnt,
      input logic          so
   );
      logic [N:0] r;
      r = {so, v};
      for (int i = 0; i < N; i++)
         if (AW'(i) < cnt)
            r = step(r[N-1:0], d, m, si);
      barrel = r;
   endfunction

   assign nxt = barrel(q_r, bus.dir, bus.mode, bus.ser_in, k, so_r);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_r    <= '0;
         so_r   <= 1'b0;
         done_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (bus.load) begin
            q_r <= bus.data_in;
         end else if (bus.start) begin
            {so_r, q_r} <= nxt;
            done_r      <= 1'b1;
         end
      end
   end

   assign bus.busy = 1'b0;
`else
   typedef enum logic {IDLE, SHIFT} state_t;

   state_t        state;
   logic          busy_r;
   logic [AW-1:0] cnt;
   logic          dir_r;
   logic [1:0]    mode_r;

   // ser_in is live during SHIFT so a serial stream can be clocked in.
   assign nxt = step(q_r, dir_r, mode_r, bus.ser_in);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         q_r    <= '0;
         so_r   <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         cnt    <= '0;
         dir_r  <= 1'b0;
         mode_r <= 2'b00;
      end else begin
         done_r <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.load) begin
                  q_r <= bus.data_in;
               end else if (bus.start) begin
                  if (k == '0) begin
                     done_r <= 1'b1;
                  end else begin
                     dir_r  <= bus.dir;
                     mode_r <= bus.mode;
                     cnt    <= k;
                     busy_r <= 1'b1;
                     state  <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               {so_r, q_r} <= nxt;
               cnt         <= cnt - AW'(1);
               if (cnt == AW'(1)) begin
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy = busy_r;
`endif

   assign bus.q       = q_r;
   assign bus.ser_out = so_r;
   assign bus.done    = done_r;
endmodule

// File: tb/tb_universal_shift_register.sv
// Directed self-checking bench for universal_shift_register (N=8).
// Inputs change on falling edges; outputs sampled on falling edges.
module tb_universal_shift_register;
   logic clk = 1'b0;
   logic rst;
   int   compared = 0;
   int   mismatched = 0;

   universal_shift_register_if #(.N(8)) bus ();

   universal_shift_register #(.N(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic ld(input logic [7:0] v);
      @(negedge clk);
      bus.load    = 1'b1;
      bus.data_in = v;
      @(negedge clk);
      bus.load    = 1'b0;
      chk("load_q", 32'(bus.q), 32'(v));
   endtask

   task automatic cmd(input string tag, input logic d, input logic [1:0] m,
                      input logic [3:0] a, input logic si,
                      input logic [7:0] eq, input logic eso,
                      input int ek, input bit inj);
      int nb;
      int nd;
      int both;
      nb = 0;
      nd = 0;
      both = 0;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.dir    = d;
      bus.mode   = m;
      bus.amt    = a;
      bus.ser_in = si;
      @(negedge clk);
      bus.start = 1'b0;
      bus.dir   = ~d;
      bus.amt   = 4'd1;
      for (int i = 0; i < 20; i++) begin
         if (bus.busy) nb++;
         if (bus.done) nd++;
         if (bus.busy && bus.done) both++;
         if (inj && i == 0) begin
            bus.load    = 1'b1;
            bus.data_in = 8'h00;
            bus.start   = 1'b1;
         end else begin
            bus.load  = 1'b0;
            bus.start = 1'b0;
         end
         @(negedge clk);
      end
      chk({tag, "_q"}, 32'(bus.q), 32'(eq));
      chk({tag, "_ser_out"}, 32'(bus.ser_out), 32'(eso));
      chk({tag, "_busy_cycles"}, 32'(nb), 32'(ek));
      chk({tag, "_done_pulses"}, 32'(nd), 32'd1);
      chk({tag, "_busy_and_done"}, 32'(both), 32'd0);
   endtask

   initial begin
      int nd;
      rst         = 1'b0;
      bus.load    = 1'b0;
      bus.start   = 1'b0;
      bus.dir     = 1'b0;
      bus.mode    = 2'b00;
      bus.amt     = '0;
      bus.data_in = '0;
      bus.ser_in  = 1'b0;
      #8;
      chk("rst_q", 32'(bus.q), 32'h0);
      chk("rst_ser_out", 32'(bus.ser_out), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_done", 32'(bus.done), 32'h0);
      @(negedge clk);
      rst = 1'b1;

      ld(8'hEA);
      chk("load_busy", 32'(bus.busy), 32'h0);
      chk("load_done", 32'(bus.done), 32'h0);

      cmd("shl_log3", 1'b0, 2'b00, 4'd3, 1'b0, 8'h50, 1'b1, 3, 1'b0);

      ld(8'hEA);
      cmd("shr_ari2", 1'b1, 2'b01, 4'd2, 1'b0, 8'hFA, 1'b1, 2, 1'b0);

      ld(8'hEA);
      cmd("ror4", 1'b1, 2'b10, 4'd4, 1'b0, 8'hAE, 1'b1, 4, 1'b0);

      ld(8'hEA);
      cmd("ror8", 1'b1, 2'b10, 4'd8, 1'b0, 8'hEA, 1'b1, 8, 1'b0);

      cmd("amt0", 1'b0, 2'b00, 4'd0, 1'b0, 8'hEA, 1'b1, 0, 1'b0);

      cmd("shl_amt15", 1'b0, 2'b00, 4'd15, 1'b0, 8'h00, 1'b0, 8, 1'b0);

      ld(8'h0F);
      cmd("shr_log_ser1", 1'b1, 2'b00, 4'd4, 1'b1, 8'hF0, 1'b1, 4, 1'b0);

      ld(8'hEA);
      cmd("rol2_ignore", 1'b0, 2'b10, 4'd2, 1'b0, 8'hAB, 1'b1, 2, 1'b1);

      ld(8'hEA);
      @(negedge clk);
      bus.start  = 1'b1;
      bus.dir    = 1'b0;
      bus.mode   = 2'b00;
      bus.amt    = 4'd5;
      bus.ser_in = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mid_q_after2", 32'(bus.q), 32'hA8);
      #2;
      rst = 1'b0;
      #1;
      chk("abort_q", 32'(bus.q), 32'h0);
      chk("abort_busy", 32'(bus.busy), 32'h0);
      chk("abort_ser_out", 32'(bus.ser_out), 32'h0);
      nd = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.done) nd++;
         if (i == 2) rst = 1'b1;
      end
      chk("abort_no_done", 32'(nd), 32'd0);
      chk("abort_idle_busy", 32'(bus.busy), 32'h0);
      ld(8'h3C);
      chk("post_rst_busy", 32'(bus.busy), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end
endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
Parametrised successor to the basic load/shift register. Adds a multi-bit shift-amount command, logical/arithmetic/rotate modes, serial in/out, and a busy/done handshake around a small FSM. Used as a datapath utility in shift/serialise paths where a controller issues "shift by K" commands and waits for completion.

Parameters:
N, 8, register width in bits (N >= 2)
AW, $clog2(N)+1, derived localparam: width of the shift-amount port; holds values 0..N

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  asynchronous active-low reset; asserted (0) clears all state immediately
load  input  1  parallel load request (IDLE only)
start  input  1  shift command request (IDLE only)
dir  input  1  0 = shift left (toward MSB), 1 = shift right (toward LSB)
mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical)
amt  input  AW  number of bit positions to shift; values > N clamped to N
data_in  input  N  parallel load data
ser_in  input  1  serial fill bit for logical shifts
q  output  N  register contents
ser_out  output  1  last bit shifted out of the register (registered)
busy  output  1  high while a shift command is executing
done  output  1  one-cycle pulse when a command completes

Behaviour:
- Reset (rst=0, async): q=0, ser_out=0, busy=0, done=0, FSM=IDLE, internal count=0. Reset mid-command aborts it; no done pulse.
- FSM states: IDLE, SHIFT.
- IDLE, load=1: q <= data_in at the next edge. load has priority over start when both high; start ignored that cycle.
- IDLE, start=1, amt=0: no shift; done=1 for one cycle after the edge; busy stays 0; q, ser_out unchanged.
- IDLE, start=1, amt>0: at accept edge E0 latch dir, mode, min(amt,N) into internal regs; busy=1; go SHIFT. dir/mode/amt inputs are don't-care afterwards.
- SHIFT: one-bit shift per edge E1..EK (K = clamped amt). Counter decrements each edge. At EK: busy->0, done->1 (one cycle), FSM->IDLE. Total command latency K+1 edges from accept.
- load/start while busy: ignored, no effect, no error.
- Per-step fill rules:
  left logical: q <= {q[N-2:0], ser_in}; ser_out <= q[N-1]
  left arithmetic: q <= {q[N-2:0], 1'b0}; ser_out <= q[N-1]
  right logical: q <= {ser_in, q[N-1:1]}; ser_out <= q[0]
  right arithmetic: q <= {q[N-1], q[N-1:1]}; ser_out <= q[0]
  rotate left/right: wrapped bit re-enters the other end; ser_out <= wrapped bit
- ser_in sampled at every shift edge (a bit stream may be shifted in).
- amt=N rotate returns original value; amt=N logical with ser_in=0 yields 0.
- done and busy never high in the same cycle.

Optional Feature:
SHIFT_BARREL_EN: when defined, shift commands complete in one edge via a barrel shifter: start with any amt accepted at E0, q holds the full K-bit result after E0, busy never asserts, done pulses in the cycle after E0. Logical fill positions all take the ser_in value sampled at E0; ser_out = last bit that the equivalent serial shift would emit. When undefined, the multi-cycle FSM above is used. Final q/ser_out values are identical in both builds for constant ser_in.

Test Plan:
- Assert rst=0 10 ns, release, load=1 with data_in=8'hEA -> q=8'hEA after one edge, busy=0, done=0.
- From 8'hEA: start, dir=0, mode=00, amt=3, ser_in=0 -> busy high 3 cycles, q=8'h50, ser_out=1, single done pulse.
- From 8'hEA: start, dir=1, mode=01, amt=2 -> q=8'hFA, ser_out=1; then dir=1, mode=10, amt=4 from 8'hEA -> q=8'hAE; amt=8 rotate -> q=8'hEA.
- start with amt=0 -> done pulses next cycle, busy stays 0, q unchanged; amt=15 (N=8) -> behaves as amt=8.
- During busy, pulse load with data_in=8'h00 and start -> both ignored, command result unchanged.
- Drive rst=0 mid-SHIFT (after 2 of 5 steps) -> q=0, busy=0 immediately without a clock edge, no done pulse; after release, load works normally.
